lpif_txrx_half_pack_ctrl: RTL and testbench

Upstream packing controller for the half-rate LPIF x1 asymmetric link. It accepts single 42-bit LPIF beats from the adapter one per clock and pairs two beats into one 84-bit TX FIFO word. It pads and flushes a lone beat after an idle timeout or on request, and applies backpressure from the TX FIFO. It sits between the LPIF upstream beat source and the `txfifo_upstream_data` input of the half-rate packing wrapper and logic-link TX FIFO.

---
 rtl/lpif_txrx_half_pack_ctrl_pkg.sv | 30 +++
 rtl/lpif_txrx_half_pack_ctrl_if.sv | 25 ++
 rtl/lpif_txrx_half_pack_ctrl_flush_timer.sv | 33 +++
 rtl/lpif_txrx_half_pack_ctrl.sv | 113 +++++++++++
 tb/tb_lpif_txrx_half_pack_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpif_txrx_half_pack_ctrl_pkg.sv
// Shared definitions for the half-rate LPIF pack/unpack controllers:
// beat layout, packer states and the pad beat.
package lpif_half_pkg;

    localparam int BEAT_W        = 42;
    localparam int STATE_LSB     = 0;
    localparam int STATE_W       = 4;
    localparam int PROTID_LSB    = 4;
    localparam int PROTID_W      = 2;
    localparam int DATA_LSB      = 6;
    localparam int DATA_W        = 32;
    localparam int DVALID_BIT    = 38;
    localparam int CRC_BIT       = 39;
    localparam int CRC_VALID_BIT = 40;
    localparam int VALID_BIT     = 41;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } pack_state_e;

    // Valid bit is 0, so the receiver discards a padded upper half.
    localparam logic [BEAT_W-1:0] PAD_BEAT = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lpif_txrx_half_pack_ctrl_if.sv
// Beat-in / TX FIFO-out bundle of the half-rate packer. master = upstream
// source and FIFO side, slave = the packing controller.
interface lpif_txrx_half_pack_ctrl_if #(
    parameter int BEAT_W = lpif_half_pkg::BEAT_W
);
    logic                  m_gen2_mode;
    logic [BEAT_W-1:0]     beat_in_data;
    logic                  beat_in_valid;
    logic                  beat_in_ready;
    logic                  flush_req;
    logic                  txfifo_full;
    logic                  txfifo_push;
    logic [2*BEAT_W-1:0]   txfifo_upstream_data;
    logic [15:0]           pad_cnt;

    modport master (
        output m_gen2_mode, beat_in_data, beat_in_valid, flush_req, txfifo_full,
        input  beat_in_ready, txfifo_push, txfifo_upstream_data, pad_cnt
    );

    modport slave (
        input  m_gen2_mode, beat_in_data, beat_in_valid, flush_req, txfifo_full,
        output beat_in_ready, txfifo_push, txfifo_upstream_data, pad_cnt
    );
endinterface

// File: rtl/lpif_txrx_half_pack_ctrl_flush_timer.sv
// Idle-cycle counter shared by the pack and unpack controllers; tc_o flags
// the last idle cycle before a lone beat must be flushed.
module lpif_half_flush_timer #(
    parameter int unsigned TC = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 8'(TC - 1));
endmodule

// File: rtl/lpif_txrx_half_pack_ctrl.sv
// Upstream packer: pairs two LPIF beats into one TX FIFO word (gen2) or pads
// single beats (gen1 / idle timeout / flush), with FIFO backpressure.
module lpif_txrx_half_pack_ctrl #(
    parameter int          BEAT_W       = lpif_half_pkg::BEAT_W,
    parameter int unsigned FLUSH_CYCLES = 8
) (
    input  logic                       clk_wr,
    input  logic                       rst_wr,
    lpif_txrx_half_pack_ctrl_if.slave  bus
);
    import lpif_half_pkg::*;

    pack_state_e        state_q, state_d;
    logic [BEAT_W-1:0]  lo_q, lo_d;
    logic [BEAT_W-1:0]  hi_q, hi_d;
    logic [15:0]        pad_cnt_q, pad_cnt_d;

    logic ready;
    logic push;
    logic accept;
    logic pad_inc;
    logic tmr_clr;
    logic tmr_inc;
    logic tmr_tc;

    lpif_half_flush_timer #(
        .TC (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk_i (clk_wr),
        .rst_i (rst_wr),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pad_inc = 1'b0;
        tmr_clr = 1'b1;
        tmr_inc = 1'b0;
        ready   = !rst_wr && ((state_q != FULL) || !bus.txfifo_full);
        push    = (state_q == FULL) && !bus.txfifo_full;
        accept  = bus.beat_in_valid && ready;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    lo_d = bus.beat_in_data;
                    if (bus.m_gen2_mode) begin
                        state_d = HALF;
                    end else begin
                        hi_d    = BEAT_W'(PAD_BEAT);
                        state_d = FULL;
                        pad_inc = 1'b1;
                    end
                end
            end
            HALF: begin
                // A beat arriving with flush completes the pair rather than padding.
                if (accept) begin
                    hi_d    = bus.beat_in_data;
                    state_d = FULL;
                end else if (bus.flush_req || tmr_tc || !bus.m_gen2_mode) begin
                    hi_d    = BEAT_W'(PAD_BEAT);
                    state_d = FULL;
                    pad_inc = 1'b1;
                end else begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            FULL: begin
                if (push) begin
                    if (accept) begin
                        lo_d = bus.beat_in_data;
                        if (bus.m_gen2_mode) begin
                            state_d = HALF;
                        end else begin
                            hi_d    = BEAT_W'(PAD_BEAT);
                            pad_inc = 1'b1;
                        end
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        pad_cnt_d = pad_inc ? sat_inc16(pad_cnt_q) : pad_cnt_q;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q   <= EMPTY;
            lo_q      <= '0;
            hi_q      <= '0;
            pad_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    assign bus.beat_in_ready        = ready;
    assign bus.txfifo_push          = push;
    assign bus.txfifo_upstream_data = {hi_q, lo_q};
    assign bus.pad_cnt              = pad_cnt_q;
endmodule

// File: tb/tb_lpif_txrx_half_pack_ctrl.sv
// Self-checking bench for lpif_txrx_half_pack_ctrl: directed scenarios plus a
// randomized run against a queue-based model of the packing rules.
module tb_lpif_txrx_half_pack_ctrl;
    localparam int BW = 42;
    localparam int VB = 41;
    localparam int FC = 8;

    typedef logic [BW-1:0]   beat_t;
    typedef logic [2*BW-1:0] word_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lpif_txrx_half_pack_ctrl_if #(.BEAT_W(BW)) bus();

    lpif_txrx_half_pack_ctrl #(
        .BEAT_W       (BW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_wr (clk),
        .rst_wr (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held lone beat, completed words awaiting push.
    beat_t ml[$];
    word_t mw[$];
    int    midle;
    int    mpad;

    logic  exp_push, exp_ready;
    word_t exp_data;
    int    exp_pad;
    logic  act_push, act_ready;
    word_t act_data;
    logic [15:0] act_pad;

    function automatic beat_t rbeat();
        beat_t b;
        b = beat_t'({$urandom, $urandom});
        b[VB] = 1'b1;
        return b;
    endfunction

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    // One clock: drive inputs, sample outputs at negedge, advance the model.
    task automatic cycle(input logic rs, input logic v, input beat_t d,
                         input logic f, input logic fl, input logic g2);
        logic acc;
        rst                = rs;
        bus.beat_in_valid  = v;
        bus.beat_in_data   = d;
        bus.txfifo_full    = f;
        bus.flush_req      = fl;
        bus.m_gen2_mode    = g2;
        exp_ready = !rs && !(mw.size() > 0 && f);
        exp_push  = (mw.size() > 0) && !f;
        exp_data  = (mw.size() > 0) ? mw[0] : '0;
        @(negedge clk);
        act_push  = bus.txfifo_push;
        act_ready = bus.beat_in_ready;
        act_data  = bus.txfifo_upstream_data;
        if (rs) begin
            ml.delete(); mw.delete(); midle = 0; mpad = 0;
        end else begin
            acc = v && exp_ready;
            if (exp_push) void'(mw.pop_front());
            if (acc) begin
                if (ml.size() > 0) begin
                    mw.push_back({d, ml[0]}); ml.delete();
                end else if (g2) begin
                    ml.push_back(d); midle = 0;
                end else begin
                    mw.push_back({beat_t'(0), d}); mpad = sat(mpad);
                end
            end else if (ml.size() > 0) begin
                if (fl || midle == FC - 1 || !g2) begin
                    mw.push_back({beat_t'(0), ml[0]}); ml.delete(); mpad = sat(mpad);
                end else begin
                    midle++;
                end
            end
        end
        exp_pad = mpad;
        @(posedge clk);
        #1;
        act_pad = bus.pad_cnt;
    endtask

    task automatic test_reset();
        cycle(1, 0, '0, 0, 0, 1);
        cycle(1, 0, '0, 0, 0, 1);
        checks++; if (act_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", act_ready); end
        checks++; if (act_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b exp 0", act_push); end
        checks++; if (act_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", act_data); end
        checks++; if (act_pad !== 16'd0) begin errors++; $display("FAIL reset_pad got %0d exp 0", act_pad); end
        cycle(0, 0, '0, 0, 0, 1);
        checks++; if (act_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", act_ready); end
    endtask

    task automatic test_stream();
        beat_t b[10];
        int    pad0 = mpad;
        int    npush = 0;
        foreach (b[i]) b[i] = rbeat();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) cycle(0, 1, b[i], 0, 0, 1);
            else        cycle(0, 0, '0, 0, 0, 1);
            if (act_push === 1'b1) npush++;
            checks++;
            if (act_push !== (i >= 2 && i <= 10 && i % 2 == 0)) begin
                errors++; $display("FAIL stream_push i=%0d got %b", i, act_push);
            end else if (act_push && act_data !== {b[i-1], b[i-2]}) begin
                errors++; $display("FAIL stream_data i=%0d got %h exp %h", i, act_data, {b[i-1], b[i-2]});
            end
        end
        checks++; if (npush != 5) begin errors++; $display("FAIL stream_count got %0d exp 5", npush); end
        checks++; if (act_pad !== 16'(pad0)) begin errors++; $display("FAIL stream_pad got %0d exp %0d", act_pad, pad0); end
    endtask

    task automatic test_flush_timeout();
        beat_t b0 = rbeat();
        int    pad0 = mpad;
        cycle(0, 1, b0, 0, 0, 1);
        for (int i = 1; i <= FC + 3; i++) begin
            cycle(0, 0, '0, 0, 0, 1);
            checks++;
            if (act_push !== (i == FC + 1)) begin
                errors++; $display("FAIL timeout_push i=%0d got %b exp %b", i, act_push, (i == FC + 1));
            end else if (act_push && (act_data !== {beat_t'(0), b0} || act_data[BW+VB] !== 1'b0)) begin
                errors++; $display("FAIL timeout_data got %h exp %h", act_data, {beat_t'(0), b0});
            end
        end
        checks++; if (act_pad !== 16'(pad0 + 1)) begin errors++; $display("FAIL timeout_pad got %0d exp %0d", act_pad, pad0 + 1); end
    endtask

    task automatic test_flush_req();
        beat_t b0 = rbeat();
        int    pad0 = mpad;
        cycle(0, 1, b0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, '0, 0, (i == 2), 1);
            checks++;
            if (act_push !== (i == 3)) begin
                errors++; $display("FAIL flushreq_push i=%0d got %b exp %b", i, act_push, (i == 3));
            end else if (act_push && act_data !== {beat_t'(0), b0}) begin
                errors++; $display("FAIL flushreq_data got %h exp %h", act_data, {beat_t'(0), b0});
            end
        end
        checks++; if (act_pad !== 16'(pad0 + 1)) begin errors++; $display("FAIL flushreq_pad got %0d exp %0d", act_pad, pad0 + 1); end
    endtask

    task automatic test_flush_coincident();
        beat_t b0 = rbeat();
        beat_t b1 = rbeat();
        int    pad0 = mpad;
        cycle(0, 1, b0, 0, 0, 1);
        cycle(0, 1, b1, 0, 1, 1);
        cycle(0, 0, '0, 0, 0, 1);
        checks++; if (act_push !== 1'b1 || act_data !== {b1, b0}) begin
            errors++; $display("FAIL coincident_word got %b/%h exp 1/%h", act_push, act_data, {b1, b0});
        end
        cycle(0, 0, '0, 0, 0, 1);
        checks++; if (act_pad !== 16'(pad0)) begin errors++; $display("FAIL coincident_pad got %0d exp %0d", act_pad, pad0); end
    endtask

    task automatic test_backpressure();
        beat_t b0 = rbeat();
        beat_t b1 = rbeat();
        beat_t b2 = rbeat();
        beat_t b3 = rbeat();
        cycle(0, 1, b0, 0, 0, 1);
        cycle(0, 1, b1, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, b2, 1, 0, 1);
            checks++;
            if (act_push !== 1'b0 || act_ready !== 1'b0 || act_data !== {b1, b0}) begin
                errors++; $display("FAIL bp_hold i=%0d got push=%b rdy=%b data=%h exp 0/0/%h", i, act_push, act_ready, act_data, {b1, b0});
            end
        end
        cycle(0, 1, b2, 0, 0, 1);
        checks++;
        if (act_push !== 1'b1 || act_ready !== 1'b1 || act_data !== {b1, b0}) begin
            errors++; $display("FAIL bp_release got push=%b rdy=%b data=%h exp 1/1/%h", act_push, act_ready, act_data, {b1, b0});
        end
        cycle(0, 1, b3, 0, 0, 1);
        cycle(0, 0, '0, 0, 0, 1);
        checks++;
        if (act_push !== 1'b1 || act_data !== {b3, b2}) begin
            errors++; $display("FAIL bp_next got push=%b data=%h exp 1/%h", act_push, act_data, {b3, b2});
        end
    endtask

    task automatic test_gen1();
        beat_t b0 = rbeat();
        beat_t b1 = rbeat();
        int    pad0 = mpad;
        word_t w;
        for (int i = 0; i < 4; i++) begin
            cycle(0, (i < 2), (i == 0) ? b0 : b1, 0, 0, 0);
            w = (i == 1) ? {beat_t'(0), b0} : {beat_t'(0), b1};
            checks++;
            if (act_push !== (i == 1 || i == 2)) begin
                errors++; $display("FAIL gen1_push i=%0d got %b", i, act_push);
            end else if (act_push && act_data !== w) begin
                errors++; $display("FAIL gen1_data i=%0d got %h exp %h", i, act_data, w);
            end
        end
        checks++; if (act_pad !== 16'(pad0 + 2)) begin errors++; $display("FAIL gen1_pad got %0d exp %0d", act_pad, pad0 + 2); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, rbeat(), 0, 0, 1);
        cycle(1, 0, '0, 0, 0, 1);
        checks++; if (act_push !== 1'b0 || act_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_during got push=%b rdy=%b exp 0/0", act_push, act_ready);
        end
        for (int i = 0; i < FC + 4; i++) begin
            cycle(0, 0, '0, 0, 0, 1);
            checks++;
            if (act_push !== 1'b0 || act_data !== '0 || act_pad !== 16'd0 || act_ready !== 1'b1) begin
                errors++; $display("FAIL rstmid_after i=%0d got push=%b data=%h pad=%0d rdy=%b", i, act_push, act_data, act_pad, act_ready);
            end
        end
    endtask

    task automatic test_random();
        logic g2 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) g2 = ~g2;
            cycle(0, ($urandom_range(0, 3) != 0), rbeat(), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), g2);
            checks++;
            if (act_push !== exp_push || act_ready !== exp_ready) begin
                errors++; $display("FAIL rand_hs i=%0d got push=%b rdy=%b exp %b/%b", i, act_push, act_ready, exp_push, exp_ready);
            end else if (exp_push && act_data !== exp_data) begin
                errors++; $display("FAIL rand_data i=%0d got %h exp %h", i, act_data, exp_data);
            end else if (act_pad !== 16'(exp_pad)) begin
                errors++; $display("FAIL rand_pad i=%0d got %0d exp %0d", i, act_pad, exp_pad);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65540; i++) cycle(0, 1, rbeat(), 0, 0, 0);
        checks++; if (act_pad !== 16'hFFFF) begin errors++; $display("FAIL sat_pad got %h exp ffff", act_pad); end
        checks++; if (act_push !== 1'b1) begin errors++; $display("FAIL sat_push got %b exp 1", act_push); end
        cycle(0, 1, rbeat(), 0, 0, 0);
        checks++; if (act_pad !== 16'hFFFF || exp_pad != 65535) begin errors++; $display("FAIL sat_hold got %h exp ffff", act_pad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        midle  = 0;
        mpad   = 0;
        test_reset();
        test_stream();
        test_flush_timeout();
        test_flush_req();
        test_flush_coincident();
        test_backpressure();
        test_gen1();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
